// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite encodings and the SRAM slave FSM state type.
package ahb3lite_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings (only byte/half/word are legal for this slave)
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Slave FSM states
  typedef enum logic [2:0] {
    SLV_IDLE = 3'd0,
    SLV_WAIT = 3'd1,
    SLV_DATA = 3'd2,
    SLV_ERR1 = 3'd3,
    SLV_ERR2 = 3'd4
  } slv_state_e;

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enabled word array: synchronous write, combinational read.
// Contents are deliberately not reset.
module ahb_sram_mem #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Write the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // A read in the cycle after a write sees the written value because the
  // array is read combinationally from the already-updated storage.
  assign rdata = mem_q[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB3-Lite SRAM slave: address-phase capture, error checking, optional
// wait states, two-cycle ERROR response, byte-lane writes.
//
// Handshake: a transfer is accepted at a rising edge where HSEL=1,
// HREADY=1 and HTRANS is NONSEQ/SEQ. Its data phase lasts until the first
// edge where HREADYOUT=1; that edge both completes the current transfer and
// may accept the next one (zero-bubble pipelining). While HREADYOUT=0 the
// bus holds HREADY low, so new address phases are ignored.
module ahb_sram_slave
  import ahb3lite_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [15:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW         = $clog2(WAIT_STATES + 2);
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_DEPTH * 4);

  slv_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;

  logic          accept;
  logic          sample_window;
  logic          size_err, align_err, range_err, req_err;
  logic [3:0]    mem_be;
  logic          mem_we;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] word_addr;
  logic          unused_inputs;

  // HBURST and HPROT carry no meaning for a flat SRAM.
  assign unused_inputs = ^{HBURST, HPROT, addr_q};

  // Address-phase decode and legality checks on the live bus.
  always_comb begin
    accept    = HSEL && HREADY && HTRANS[1];
    size_err  = (HSIZE > HSIZE_WORD);
    align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    range_err = ({16'h0000, HADDR} >= ADDR_LIMIT);
    req_err   = size_err || align_err || range_err;
  end

  // Only states that drive HREADYOUT=1 can sample a new address phase.
  assign sample_window = (state_q == SLV_IDLE) || (state_q == SLV_DATA) ||
                         (state_q == SLV_ERR2);

  // Next-state logic, wait counter and address-phase latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;

    case (state_q)
      SLV_WAIT: begin
        if (cnt_q == '0) begin
          state_d = SLV_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SLV_ERR1: state_d = SLV_ERR2;
      default:  ;
    endcase

    if (sample_window) begin
      if (accept) begin
        addr_d  = HADDR;
        write_d = HWRITE;
        size_d  = HSIZE;
        if (req_err) begin
          state_d = SLV_ERR1;
        end else if (WAIT_STATES > 0) begin
          state_d = SLV_WAIT;
          // Counter runs from WAIT_STATES-1 down to 0: one WAIT cycle each.
          cnt_d   = CW'(WAIT_STATES - 1);
        end else begin
          state_d = SLV_DATA;
        end
      end else begin
        state_d = SLV_IDLE;
      end
    end
  end

  // State and latched address-phase registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= SLV_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  // Little-endian byte-lane enables from the latched size and address.
  always_comb begin
    mem_be = 4'b0000;
    case (size_q)
      HSIZE_BYTE: mem_be = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:    mem_be = 4'b1111;
    endcase
  end

  assign word_addr = addr_q[AW+1:2];

  // Bus outputs and memory write strobe, decoded from the current state.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = 32'h0000_0000;
    mem_we    = 1'b0;
    case (state_q)
      SLV_WAIT: HREADYOUT = 1'b0;
      SLV_DATA: begin
        if (write_q) begin
          mem_we = 1'b1;
        end else begin
          HRDATA = mem_rdata;
        end
      end
      SLV_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      SLV_ERR2: HRESP = HRESP_ERROR;
      default:  ;
    endcase
  end

  ahb_sram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (word_addr),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

endmodule
